// File: rtl/ex_div_seq_if.sv
// Handshake bundle between the EX stage and the multi-cycle divide sequencer.
// The EX side (master) drives the request and flush; the sequencer (slave)
// returns ready/stall and the one-cycle result pulse.
interface ex_div_seq_if #(
  parameter int XLEN = 64
);
  logic            i_valid;
  logic [1:0]      i_op;
  logic            i_word;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic            i_flush;
  logic            o_ready;
  logic            o_stall;
  logic            o_valid;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_valid, i_op, i_word, i_rs1, i_rs2, i_flush,
    input  o_ready, o_stall, o_valid, o_result
  );

  modport slave (
    input  i_valid, i_op, i_word, i_rs1, i_rs2, i_flush,
    output o_ready, o_stall, o_valid, o_result
  );
endinterface

// File: rtl/ex_div_seq.sv
// Multi-cycle RV64M divide/remainder sequencer (DIV/DIVU/REM/REMU and W forms).
// Restoring radix-2 divider on operand magnitudes: 32 or 64 iterations, then
// sign fix-up and a one-cycle result pulse. Divide-by-zero and signed overflow
// bypass the iteration loop and answer two cycles after acceptance.
module ex_div_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic         clk,
  input  logic         rst,
  ex_div_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Word results are always the sign-extension of bit 31, even for unsigned ops.
  function automatic logic [XLEN-1:0] fit_word(input logic [XLEN-1:0] v, input logic w);
    logic [XLEN-1:0] r;
    if (w) begin
      r = {{(XLEN-32){v[31]}}, v[31:0]};
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       op_r;
  logic             word_r;
  logic [XLEN-1:0]  rs1_r;
  logic [XLEN-1:0]  rs2_r;
  logic [XLEN-1:0]  quo_r;
  logic [XLEN-1:0]  rem_r;
  logic [XLEN-1:0]  div_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic [XLEN-1:0]  res_r;
  logic             done_r;
  logic             ready_r;
  logic             stall_r;

  logic             signed_op_s;
  logic [XLEN-1:0]  a_ext_s;
  logic [XLEN-1:0]  b_ext_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [XLEN-1:0]  a_mag_s;
  logic [XLEN-1:0]  b_mag_s;
  logic [XLEN-1:0]  min_val_s;
  logic             div_zero_s;
  logic             ovf_s;
  logic [XLEN-1:0]  dvd_init_s;
  logic [XLEN-1:0]  sp_sel_s;
  logic [CNT_W-1:0] iter_n_s;
  logic [XLEN:0]    shifted_s;
  logic [XLEN:0]    trial_s;
  logic [XLEN-1:0]  quo_nx_s;
  logic [XLEN-1:0]  rem_nx_s;
  logic [XLEN-1:0]  fix_sel_s;

  // Operand preparation from the captured request: extension, magnitudes, special cases.
  always_comb begin
    signed_op_s = ~op_r[0];
    if (word_r) begin
      a_ext_s   = signed_op_s ? {{(XLEN-32){rs1_r[31]}}, rs1_r[31:0]} : {{(XLEN-32){1'b0}}, rs1_r[31:0]};
      b_ext_s   = signed_op_s ? {{(XLEN-32){rs2_r[31]}}, rs2_r[31:0]} : {{(XLEN-32){1'b0}}, rs2_r[31:0]};
      min_val_s = {{(XLEN-31){1'b1}}, {31{1'b0}}};
      iter_n_s  = CNT_W'(32);
    end else begin
      a_ext_s   = rs1_r;
      b_ext_s   = rs2_r;
      min_val_s = {1'b1, {(XLEN-1){1'b0}}};
      iter_n_s  = CNT_W'(XLEN);
    end
    a_neg_s    = signed_op_s & a_ext_s[XLEN-1];
    b_neg_s    = signed_op_s & b_ext_s[XLEN-1];
    a_mag_s    = a_neg_s ? ({XLEN{1'b0}} - a_ext_s) : a_ext_s;
    b_mag_s    = b_neg_s ? ({XLEN{1'b0}} - b_ext_s) : b_ext_s;
    div_zero_s = (b_ext_s == {XLEN{1'b0}});
    ovf_s      = signed_op_s & (a_ext_s == min_val_s) & (b_ext_s == {XLEN{1'b1}});
    // Word dividends sit in the top half so 32 shifts walk every dividend bit out.
    if (word_r) begin
      dvd_init_s = a_mag_s << (XLEN-32);
    end else begin
      dvd_init_s = a_mag_s;
    end
    if (div_zero_s) begin
      sp_sel_s = op_r[1] ? a_ext_s : {XLEN{1'b1}};
    end else begin
      sp_sel_s = op_r[1] ? {XLEN{1'b0}} : a_ext_s;
    end
  end

  // One restoring iteration: shift {rem,quo}, trial-subtract, keep the difference if non-negative.
  always_comb begin
    shifted_s = {rem_r, quo_r[XLEN-1]};
    trial_s   = shifted_s - {1'b0, div_r};
    if (!trial_s[XLEN]) begin
      rem_nx_s = trial_s[XLEN-1:0];
      quo_nx_s = {quo_r[XLEN-2:0], 1'b1};
    end else begin
      rem_nx_s = shifted_s[XLEN-1:0];
      quo_nx_s = {quo_r[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up of the magnitude results and quotient/remainder selection.
  always_comb begin
    if (op_r[1]) begin
      fix_sel_s = r_neg_r ? ({XLEN{1'b0}} - rem_r) : rem_r;
    end else begin
      fix_sel_s = q_neg_r ? ({XLEN{1'b0}} - quo_r) : quo_r;
    end
  end

  // Sequencer FSM with registered ready/stall/result; reset beats flush beats everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      op_r    <= 2'b00;
      word_r  <= 1'b0;
      rs1_r   <= {XLEN{1'b0}};
      rs2_r   <= {XLEN{1'b0}};
      quo_r   <= {XLEN{1'b0}};
      rem_r   <= {XLEN{1'b0}};
      div_r   <= {XLEN{1'b0}};
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      res_r   <= {XLEN{1'b0}};
      done_r  <= 1'b0;
      ready_r <= 1'b1;
      stall_r <= 1'b0;
    end else if ((state_r != S_IDLE) && bus.i_flush) begin
      state_r <= S_IDLE;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
      stall_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.i_valid && ready_r && !bus.i_flush) begin
            op_r    <= bus.i_op;
            word_r  <= bus.i_word;
            rs1_r   <= bus.i_rs1;
            rs2_r   <= bus.i_rs2;
            ready_r <= 1'b0;
            stall_r <= 1'b1;
            state_r <= S_PREP;
          end else begin
            ready_r <= 1'b1;
            stall_r <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_PREP: begin
          q_neg_r <= a_neg_s ^ b_neg_s;
          r_neg_r <= a_neg_s;
          cnt_r   <= iter_n_s;
          if (div_zero_s || ovf_s) begin
            res_r   <= fit_word(sp_sel_s, word_r);
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end else begin
            quo_r   <= dvd_init_s;
            rem_r   <= {XLEN{1'b0}};
            div_r   <= b_mag_s;
            state_r <= S_CALC;
          end
        end
        S_CALC: begin
          quo_r <= quo_nx_s;
          rem_r <= rem_nx_s;
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r <= S_FIX;
          end else begin
            state_r <= S_CALC;
          end
        end
        S_FIX: begin
          res_r   <= fit_word(fix_sel_s, word_r);
          done_r  <= 1'b1;
          state_r <= S_DONE;
        end
        S_DONE: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          stall_r <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          stall_r <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // A flush arriving in the DONE cycle must swallow the pulse already staged.
  assign bus.o_valid  = done_r & ~bus.i_flush;
  assign bus.o_result = bus.o_valid ? res_r : {XLEN{1'b0}};
  assign bus.o_ready  = ready_r;
  assign bus.o_stall  = stall_r;

endmodule

// File: tb/tb_ex_div_seq.sv
// Scoreboard bench for ex_div_seq: the driver pushes reference results at
// acceptance, an independent negedge monitor pops and compares on o_valid.
module tb_ex_div_seq;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_div_seq_if #(.XLEN(XLEN)) bus ();
  ex_div_seq #(.XLEN(XLEN), .CNT_W(7)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          tick;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   ncyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: RISC-V M-extension semantics using plain SV arithmetic.
  task automatic ref_div(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] res, output int lat);
    logic [63:0] ea, eb, q, r, minv;
    longint sa, sb;
    bit sgn;
    sgn = (op == 2'd0) || (op == 2'd2);
    if (w) begin
      ea   = sgn ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]};
      eb   = sgn ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]};
      minv = 64'hFFFF_FFFF_8000_0000;
      lat  = 35;
    end else begin
      ea   = a;
      eb   = b;
      minv = 64'h8000_0000_0000_0000;
      lat  = 67;
    end
    if (eb == 64'd0) begin
      q = 64'hFFFF_FFFF_FFFF_FFFF; r = ea; lat = 2;
    end else if (sgn && ea == minv && eb == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q = ea; r = 64'd0; lat = 2;
    end else if (sgn) begin
      sa = ea; sb = eb;
      q = sa / sb; r = sa % sb;
    end else begin
      q = ea / eb; r = ea % eb;
    end
    res = op[1] ? r : q;
    if (w) res = {{32{res[31]}}, res[31:0]};
  endtask

  // Monitor: every negedge, pop/compare on a result pulse, else result must be zero.
  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      if (bus.o_valid) begin
        if (sb_q.size() == 0) begin
          chk("spurious_valid", {63'd0, bus.o_valid}, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("result", bus.o_result, mon_e.res);
          chk("latency", 64'(ncyc - mon_e.tick), 64'(mon_e.lat));
        end
      end else begin
        chk("idle_result_zero", bus.o_result, 64'd0);
      end
    end
  end

  // Issue one op; optionally check the stall window, flush at cycle T+flush_at, or reset at T+rst_at.
  task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input int flush_at, input int rst_at, input bit chk_stall);
    int waited = 0;
    int bad = 0;
    logic [63:0] res;
    int lat;
    exp_t e;
    @(posedge clk); #1;
    while (!bus.o_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.o_ready) begin
      chk("ready_timeout", {63'd0, bus.o_ready}, 64'd1);
      return;
    end
    bus.i_valid = 1'b1; bus.i_op = op; bus.i_word = w; bus.i_rs1 = a; bus.i_rs2 = b;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_rs1 = $urandom(); bus.i_rs2 = $urandom();
    ref_div(op, w, a, b, res, lat);
    if (flush_at == 0 && rst_at == 0) begin
      e.res = res; e.lat = lat; e.tick = ncyc;
      sb_q.push_back(e);
    end
    if (chk_stall) begin
      for (int k = 1; k <= lat; k++) begin
        if (!bus.o_stall) bad++;
        if (k < lat) begin @(posedge clk); #1; end
      end
      chk("stall_window", 64'(bad), 64'd0);
      @(posedge clk); #1;
      chk("ready_after_done", {63'd0, bus.o_ready}, 64'd1);
    end
    if (flush_at > 0) begin
      repeat (flush_at - 1) begin @(posedge clk); #1; end
      bus.i_flush = 1'b1;
      @(posedge clk); #1;
      bus.i_flush = 1'b0;
      chk("flush_stall", {63'd0, bus.o_stall}, 64'd0);
      chk("flush_ready", {63'd0, bus.o_ready}, 64'd1);
    end
    if (rst_at > 0) begin
      repeat (rst_at - 1) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_valid", {63'd0, bus.o_valid}, 64'd0);
      chk("rst_result", bus.o_result, 64'd0);
      chk("rst_stall", {63'd0, bus.o_stall}, 64'd0);
      chk("rst_ready", {63'd0, bus.o_ready}, 64'd1);
    end
  endtask

  function automatic logic [63:0] pick_val();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = 64'($urandom_range(0, 20));
      3: v = 64'h8000_0000_0000_0000;
      4: v = 64'h0000_0000_8000_0000;
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  initial begin
    int drain = 0;
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_op = 2'd0; bus.i_word = 1'b0;
    bus.i_rs1 = 64'd0; bus.i_rs2 = 64'd0; bus.i_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {63'd0, bus.o_valid}, 64'd0);
    chk("reset_result", bus.o_result, 64'd0);
    chk("reset_stall", {63'd0, bus.o_stall}, 64'd0);
    chk("reset_ready", {63'd0, bus.o_ready}, 64'd1);
    rst = 1'b0;

    run_op(2'd1, 1'b0, 64'd100, 64'd7, 0, 0, 1'b1);
    run_op(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 0, 1'b0);
    run_op(2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 0, 1'b0);
    run_op(2'd0, 1'b0, 64'd5, 64'd0, 0, 0, 1'b1);
    run_op(2'd3, 1'b0, 64'd5, 64'd0, 0, 0, 1'b0);
    run_op(2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1'b0);
    run_op(2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1'b0);
    run_op(2'd1, 1'b1, 64'h1_FFFF_FFFE, 64'd1, 0, 0, 1'b1);
    run_op(2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 0, 1'b0);

    run_op(2'd1, 1'b0, 64'd100, 64'd7, 10, 0, 1'b0);
    run_op(2'd1, 1'b0, 64'd9, 64'd3, 0, 0, 1'b0);
    run_op(2'd1, 1'b0, 64'd100, 64'd7, 0, 20, 1'b0);
    run_op(2'd1, 1'b0, 64'd9, 64'd3, 0, 0, 1'b0);
    run_op(2'd0, 1'b0, 64'd5, 64'd0, 2, 0, 1'b0);
    run_op(2'd1, 1'b1, 64'd50, 64'd5, 35, 0, 1'b0);

    // Request with flush in IDLE must be refused.
    @(posedge clk); #1;
    while (!bus.o_ready && drain < 200) begin @(posedge clk); #1; drain++; end
    bus.i_valid = 1'b1; bus.i_flush = 1'b1; bus.i_op = 2'd1; bus.i_rs1 = 64'd9; bus.i_rs2 = 64'd3;
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_flush = 1'b0;
    chk("idle_flush_stall", {63'd0, bus.o_stall}, 64'd0);
    chk("idle_flush_ready", {63'd0, bus.o_ready}, 64'd1);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick_val(), pick_val(), 0, 0, 1'b0);
    end

    drain = 0;
    while (sb_q.size() > 0 && drain < 300) begin
      @(posedge clk);
      drain++;
    end
    if (sb_q.size() > 0) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_div_seq.md
Name: ex_div_seq

Overview:
- Multi-cycle sequencer for the RV64M divide/remainder operations (DIV, DIVU, REM, REMU and their W variants).
- Sits beside the single-cycle execute ALU in the EX stage.
- Accepts one operation from EX, runs a shared restoring radix-2 divider datapath for 32 or 64 iterations, then returns a one-cycle result pulse.
- Holds the pipeline stall request while busy and abandons work on flush.

Parameters:
XLEN, 64, operand/result width
CNT_W, 7, iteration counter width (must hold XLEN)

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is synchronous and active-high
i_valid  input  1  request valid (EX holds a divide op)
i_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
i_word  input  1  1 = W variant (32-bit operation)
i_rs1  input  XLEN  dividend
i_rs2  input  XLEN  divisor
i_flush  input  1  pipeline flush; kills the operation in flight
o_ready  output  1  idle, request can be accepted this cycle
o_stall  output  1  stall request to the pipeline (state != IDLE)
o_valid  output  1  one-cycle result-valid pulse
o_result  output  XLEN  quotient or remainder; 0 when o_valid=0

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, counter=0, internal regs=0. Outputs after reset: o_valid=0, o_result=0, o_stall=0, o_ready=1.
- rst has priority over every other input, including mid-operation.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - o_ready=1.
  - Acceptance = i_valid & o_ready & !i_flush at edge T. On acceptance, capture op, word, rs1, rs2 and go to PREP. Otherwise stay in IDLE.
- PREP (cycle T+1):
  - Operand prep. Word: take bits [31:0]; sign-extend for DIV/REM, zero-extend for DIVU/REMU.
  - Signed ops: take absolute values and record quotient sign (s1^s2) and remainder sign (s1).
  - Set N = 32 (word) or 64. Load counter=N.
  - Div-by-zero (divisor==0): quotient = all ones; remainder = dividend (post-extension). Go to DONE.
  - Signed overflow (dividend = most-negative, divisor = -1, at the effective width): quotient = dividend; remainder = 0. Go to DONE.
  - Otherwise go to CALC.
- CALC (T+2 .. T+1+N):
  - Each cycle: shift {rem,quo} left 1; trial subtract divisor; if non-negative, keep the difference and set quo bit 0.
  - Counter decrements; go to FIX when the counter reaches 1 and the iteration completes.
- FIX (T+2+N): negate quotient/remainder per the recorded signs (signed ops only); select quotient (DIV*) or remainder (REM*). Go to DONE.
- DONE:
  - o_valid=1 for exactly one cycle; o_result = selected value.
  - Word ops: o_result = sign-extension of bit 31 (also for DIVUW/REMUW).
  - Next state IDLE. o_ready=0 in DONE, so back-to-back requests have a minimum 1-cycle gap.
- Latency (acceptance edge to o_valid cycle): normal = N+3 (35 word, 67 double); special cases = 2.
- o_stall = 1 in PREP, CALC, FIX, DONE; 0 in IDLE.
- Flush:
  - i_flush=1 in any non-IDLE state: next state IDLE, no o_valid, results discarded.
  - i_flush in DONE suppresses o_valid that cycle.
  - i_flush with i_valid in IDLE: request not accepted.
- i_valid/operands are ignored outside IDLE; the captured copy is used.
- All arithmetic is unsigned on magnitudes; no width truncation other than the word-mode extension above.

Test Plan:
- DIVU rs1=100, rs2=7, word=0, accepted at T -> o_valid at T+67, o_result=14; o_stall high T+1..T+67; o_ready high again T+68.
- REM rs1=-7 (0xFFFF_FFFF_FFFF_FFF9), rs2=2 -> o_result=0xFFFF_FFFF_FFFF_FFFF (-1) at T+67. Same operands with DIV -> 0xFFFF_FFFF_FFFF_FFFD (-3).
- Special cases, each with o_valid at T+2:
  - DIV 5/0 -> 0xFFFF_FFFF_FFFF_FFFF.
  - REMU 5/0 -> 5.
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
  - REM with the same operands -> 0.
- Word ops:
  - DIVUW rs1=0x1_FFFF_FFFE, rs2=1 -> o_result=0xFFFF_FFFF_FFFF_FFFE at T+35.
  - DIVW rs1=0x0000_0000_8000_0000, rs2=0xFFFF_FFFF (-1) -> overflow path, 0xFFFF_FFFF_8000_0000 at T+2.
- Flush/reset:
  - i_flush at T+10 -> state IDLE at T+11, o_valid never asserts, o_stall=0 at T+11.
  - rst at T+20 -> all outputs at reset values next cycle.
  - New DIVU 9/3 accepted after either recovery -> 3 at the normal latency.
